// File: rtl/watch_ui_ctrl.sv
// Watch UI sequencer: turns debounced button pulses and the 1 Hz tick into
// display mode, stopwatch control levels/strobes and time-set increment strobes.
//
// state       | meaning
// S_CLOCK     | time display, buttons other than mode ignored
// S_STOPWATCH | sel starts/stops, inc clears (stopped) or toggles lap (running)
// S_SET       | sel picks field, inc bumps it, idle ticks time out to S_CLOCK
module watch_ui_ctrl #(
  parameter int unsigned TIMEOUT_S = 10,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_mode,
  input  logic       i_btn_sel,
  input  logic       i_btn_inc,
  input  logic       i_tick_1hz,
  output logic [1:0] o_mode,
  output logic [1:0] o_set_field,
  output logic       o_inc_hour,
  output logic       o_inc_min,
  output logic       o_inc_sec,
  output logic       o_sw_run,
  output logic       o_sw_clear,
  output logic       o_sw_lap,
  output logic       o_blink
);

  typedef enum logic [1:0] {
    S_CLOCK     = 2'd0,
    S_STOPWATCH = 2'd1,
    S_SET       = 2'd2
  } state_t;

  localparam logic [1:0] F_HOUR = 2'd0;
  localparam logic [1:0] F_MIN  = 2'd1;
  localparam logic [1:0] F_SEC  = 2'd2;

  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);
  localparam logic [7:0]    TIMEOUT_CNT = 8'(TIMEOUT_S);

  state_t          r_state;
  logic [1:0]      r_set_field;
  logic            r_inc_hour;
  logic            r_inc_min;
  logic            r_inc_sec;
  logic            r_sw_run;
  logic            r_sw_clear;
  logic            r_sw_lap;
  logic            r_blink;
  logic [7:0]      r_to_cnt;
  logic [BW-1:0]   r_blink_cnt;

  state_t          w_state_nxt;
  logic [1:0]      w_field_nxt;
  logic            w_inc_hour_nxt;
  logic            w_inc_min_nxt;
  logic            w_inc_sec_nxt;
  logic            w_run_nxt;
  logic            w_clear_nxt;
  logic            w_lap_nxt;
  logic            w_blink_nxt;
  logic [7:0]      w_to_cnt_nxt;
  logic [BW-1:0]   w_blink_cnt_nxt;

  logic            w_mode_p;
  logic            w_sel_p;
  logic            w_inc_p;
  logic [7:0]      w_to_cnt_inc;

  // Only the highest-priority pulse in a cycle survives
  assign w_mode_p     = i_btn_mode;
  assign w_sel_p      = i_btn_sel & ~i_btn_mode;
  assign w_inc_p      = i_btn_inc & ~i_btn_mode & ~i_btn_sel;
  assign w_to_cnt_inc = r_to_cnt + 8'd1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_CLOCK;
      r_set_field <= F_HOUR;
      r_inc_hour  <= 1'b0;
      r_inc_min   <= 1'b0;
      r_inc_sec   <= 1'b0;
      r_sw_run    <= 1'b0;
      r_sw_clear  <= 1'b0;
      r_sw_lap    <= 1'b0;
      r_blink     <= 1'b1;
      r_to_cnt    <= 8'd0;
      r_blink_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_set_field <= w_field_nxt;
      r_inc_hour  <= w_inc_hour_nxt;
      r_inc_min   <= w_inc_min_nxt;
      r_inc_sec   <= w_inc_sec_nxt;
      r_sw_run    <= w_run_nxt;
      r_sw_clear  <= w_clear_nxt;
      r_sw_lap    <= w_lap_nxt;
      r_blink     <= w_blink_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
    end
  end

  // Timeout/blink defaults are their idle values; only the no-button SET path advances them
  always_comb begin
    w_state_nxt     = r_state;
    w_field_nxt     = r_set_field;
    w_inc_hour_nxt  = 1'b0;
    w_inc_min_nxt   = 1'b0;
    w_inc_sec_nxt   = 1'b0;
    w_run_nxt       = r_sw_run;
    w_clear_nxt     = 1'b0;
    w_lap_nxt       = r_sw_lap;
    w_blink_nxt     = 1'b1;
    w_to_cnt_nxt    = 8'd0;
    w_blink_cnt_nxt = '0;

    case (r_state)
      S_CLOCK: begin
        if (w_mode_p) w_state_nxt = S_STOPWATCH;
      end

      S_STOPWATCH: begin
        if (w_mode_p) begin
          w_state_nxt = S_SET;
          w_field_nxt = F_HOUR;
          w_lap_nxt   = 1'b0;
        end else if (w_sel_p) begin
          w_run_nxt = ~r_sw_run;
        end else if (w_inc_p) begin
          if (r_sw_run) begin
            w_lap_nxt = ~r_sw_lap;
          end else begin
            w_clear_nxt = 1'b1;
            w_lap_nxt   = 1'b0;
          end
        end
      end

      S_SET: begin
        if (w_mode_p) begin
          w_state_nxt = S_CLOCK;
        end else if (w_sel_p) begin
          case (r_set_field)
            F_HOUR:  w_field_nxt = F_MIN;
            F_MIN:   w_field_nxt = F_SEC;
            default: w_field_nxt = F_HOUR;
          endcase
        end else if (w_inc_p) begin
          case (r_set_field)
            F_HOUR:  w_inc_hour_nxt = 1'b1;
            F_MIN:   w_inc_min_nxt  = 1'b1;
            F_SEC:   w_inc_sec_nxt  = 1'b1;
            default: w_inc_hour_nxt = 1'b0;
          endcase
        end else if (i_tick_1hz && (w_to_cnt_inc == TIMEOUT_CNT)) begin
          w_state_nxt = S_CLOCK;
          w_field_nxt = F_HOUR;
        end else begin
          w_to_cnt_nxt = i_tick_1hz ? w_to_cnt_inc : r_to_cnt;
          if (r_blink_cnt == BLINK_LAST) begin
            w_blink_cnt_nxt = '0;
            w_blink_nxt     = ~r_blink;
          end else begin
            w_blink_cnt_nxt = r_blink_cnt + 1'b1;
            w_blink_nxt     = r_blink;
          end
        end
      end

      default: begin
        w_state_nxt = S_CLOCK;
      end
    endcase
  end

  assign o_mode      = r_state;
  assign o_set_field = r_set_field;
  assign o_inc_hour  = r_inc_hour;
  assign o_inc_min   = r_inc_min;
  assign o_inc_sec   = r_inc_sec;
  assign o_sw_run    = r_sw_run;
  assign o_sw_clear  = r_sw_clear;
  assign o_sw_lap    = r_sw_lap;
  assign o_blink     = r_blink;

endmodule

// File: tb/tb_watch_ui_ctrl.sv
// Bench for watch_ui_ctrl (TIMEOUT_S=3, BLINK_DIV=4): per-cycle vector table fed
// through an expected-output queue, plus a hand-written async reset sequence.
module tb_watch_ui_ctrl;

  logic       clk;
  logic       reset;
  logic       btn_mode, btn_sel, btn_inc, tick_1hz;
  logic [1:0] mode, set_field;
  logic       inc_hour, inc_min, inc_sec;
  logic       sw_run, sw_clear, sw_lap, blink;

  watch_ui_ctrl #(.TIMEOUT_S(3), .BLINK_DIV(4)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_btn_mode  (btn_mode),
    .i_btn_sel   (btn_sel),
    .i_btn_inc   (btn_inc),
    .i_tick_1hz  (tick_1hz),
    .o_mode      (mode),
    .o_set_field (set_field),
    .o_inc_hour  (inc_hour),
    .o_inc_min   (inc_min),
    .o_inc_sec   (inc_sec),
    .o_sw_run    (sw_run),
    .o_sw_clear  (sw_clear),
    .o_sw_lap    (sw_lap),
    .o_blink     (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       m, s, i, t;
    logic [1:0] mode, field;
    logic [2:0] inc;
    logic       run, clr, lap, blink;
  } vec_t;

  vec_t        vecs[80];
  int          nv = 0;
  logic [10:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [10:0] RST_OUT = 11'b00_00_000_0001;

  logic [10:0] w_act;
  assign w_act = {mode, set_field, inc_hour, inc_min, inc_sec, sw_run, sw_clear, sw_lap, blink};

  task automatic add(input int n, input logic m, s, i, t,
                     input logic [1:0] mo, fi, input logic [2:0] inc,
                     input logic r, c, l, b);
    vecs[nv].n = n;  vecs[nv].m = m;  vecs[nv].s = s;  vecs[nv].i = i;  vecs[nv].t = t;
    vecs[nv].mode = mo;  vecs[nv].field = fi;  vecs[nv].inc = inc;
    vecs[nv].run = r;  vecs[nv].clr = c;  vecs[nv].lap = l;  vecs[nv].blink = b;
    nv++;
  endtask

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got mode/field/inc(hms)/run/clr/lap/blink=%b required %b", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    btn_mode = 1'b0; btn_sel = 1'b0; btn_inc = 1'b0; tick_1hz = 1'b0;
  endtask

  initial begin
    // n  M S I T  mode field inc    run clr lap blink
    add(3, 0,0,0,0, 0, 0, 3'b000, 0,0,0,1);
    add(1, 0,1,0,0, 0, 0, 3'b000, 0,0,0,1);
    add(1, 0,0,1,0, 0, 0, 3'b000, 0,0,0,1);
    add(1, 0,0,0,1, 0, 0, 3'b000, 0,0,0,1);
    add(1, 1,0,0,0, 1, 0, 3'b000, 0,0,0,1);
    add(2, 0,0,0,0, 1, 0, 3'b000, 0,0,0,1);
    add(1, 1,0,0,0, 2, 0, 3'b000, 0,0,0,1);
    add(1, 0,0,0,0, 2, 0, 3'b000, 0,0,0,1);
    add(1, 1,0,0,0, 0, 0, 3'b000, 0,0,0,1);
    add(2, 0,0,0,0, 0, 0, 3'b000, 0,0,0,1);
    // stopwatch run / lap / clear
    add(1, 1,0,0,0, 1, 0, 3'b000, 0,0,0,1);
    add(1, 0,1,0,0, 1, 0, 3'b000, 1,0,0,1);
    add(2, 0,0,0,0, 1, 0, 3'b000, 1,0,0,1);
    add(1, 0,0,1,0, 1, 0, 3'b000, 1,0,1,1);
    add(1, 0,0,1,0, 1, 0, 3'b000, 1,0,0,1);
    add(1, 0,0,1,0, 1, 0, 3'b000, 1,0,1,1);
    add(1, 0,1,0,0, 1, 0, 3'b000, 0,0,1,1);
    add(1, 0,0,1,0, 1, 0, 3'b000, 0,1,0,1);
    add(1, 0,0,0,0, 1, 0, 3'b000, 0,0,0,1);
    add(1, 0,1,0,0, 1, 0, 3'b000, 1,0,0,1);
    add(1, 0,1,1,0, 1, 0, 3'b000, 0,0,0,1);
    add(1, 0,1,0,0, 1, 0, 3'b000, 1,0,0,1);
    add(1, 0,0,1,0, 1, 0, 3'b000, 1,0,1,1);
    add(1, 1,0,0,0, 2, 0, 3'b000, 1,0,0,1);
    // set fields, back-to-back pulses
    add(1, 0,0,1,0, 2, 0, 3'b100, 1,0,0,1);
    add(1, 0,1,0,0, 2, 1, 3'b000, 1,0,0,1);
    add(1, 0,0,1,0, 2, 1, 3'b010, 1,0,0,1);
    add(1, 0,1,0,0, 2, 2, 3'b000, 1,0,0,1);
    add(1, 0,0,1,0, 2, 2, 3'b001, 1,0,0,1);
    add(1, 0,1,0,0, 2, 0, 3'b000, 1,0,0,1);
    // blink phase and restart on edit
    add(3, 0,0,0,0, 2, 0, 3'b000, 1,0,0,1);
    add(2, 0,0,0,0, 2, 0, 3'b000, 1,0,0,0);
    add(1, 0,0,1,0, 2, 0, 3'b100, 1,0,0,1);
    add(3, 0,0,0,0, 2, 0, 3'b000, 1,0,0,1);
    add(1, 0,0,0,0, 2, 0, 3'b000, 1,0,0,0);
    // timeout after three quiet ticks
    add(1, 0,0,0,1, 2, 0, 3'b000, 1,0,0,0);
    add(1, 0,0,0,1, 2, 0, 3'b000, 1,0,0,0);
    add(1, 0,0,0,1, 0, 0, 3'b000, 1,0,0,1);
    // timeout restarted by a button coinciding with a tick
    add(1, 1,0,0,0, 1, 0, 3'b000, 1,0,0,1);
    add(1, 1,0,0,0, 2, 0, 3'b000, 1,0,0,1);
    add(1, 0,0,0,1, 2, 0, 3'b000, 1,0,0,1);
    add(1, 0,0,1,1, 2, 0, 3'b100, 1,0,0,1);
    add(1, 0,0,0,1, 2, 0, 3'b000, 1,0,0,1);
    add(1, 0,0,0,1, 2, 0, 3'b000, 1,0,0,1);
    add(1, 0,0,0,0, 2, 0, 3'b000, 1,0,0,1);
    add(1, 0,0,0,1, 0, 0, 3'b000, 1,0,0,1);
    // priority cases
    add(1, 1,0,0,0, 1, 0, 3'b000, 1,0,0,1);
    add(1, 1,0,0,0, 2, 0, 3'b000, 1,0,0,1);
    add(1, 0,1,0,0, 2, 1, 3'b000, 1,0,0,1);
    add(1, 1,0,1,0, 0, 1, 3'b000, 1,0,0,1);
    add(1, 0,0,0,0, 0, 1, 3'b000, 1,0,0,1);
    add(1, 1,0,0,0, 1, 1, 3'b000, 1,0,0,1);
    add(1, 1,1,1,0, 2, 0, 3'b000, 1,0,0,1);
    add(1, 0,0,1,0, 2, 0, 3'b100, 1,0,0,1);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", w_act, RST_OUT);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < nv; v++) begin
      for (int r = 0; r < vecs[v].n; r++) begin
        @(negedge clk);
        btn_mode = vecs[v].m;  btn_sel = vecs[v].s;
        btn_inc  = vecs[v].i;  tick_1hz = vecs[v].t;
        exp_q.push_back({vecs[v].mode, vecs[v].field, vecs[v].inc,
                         vecs[v].run, vecs[v].clr, vecs[v].lap, vecs[v].blink});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL scoreboard_empty: got queue size 0 required 1");
        end else begin
          check($sformatf("vec%0d_rep%0d", v, r), w_act, exp_q.pop_front());
        end
      end
    end

    // Last vector left an inc_hour strobe high in SET with the stopwatch running
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_immediate", w_act, RST_OUT);
    @(posedge clk);
    #1;
    check("reset_held", w_act, RST_OUT);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_quiet%0d", k), w_act, RST_OUT);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
